// File: rtl/ecc_scrub8_if.sv
// ecc_scrub8_if
// RAM-side bus between the ECC scrubber and the memory arbiter.
//   ram_busy : functional traffic owns the RAM this cycle
//   ram_re   : scrub read strobe, data appears on ram_rdat one cycle later
//   ram_we   : scrub write strobe
//   ram_addr : scrub address
//   ram_wdat : 12-bit Hamming word to write
//   ram_rdat : 12-bit word read back
// master = scrubber, slave = RAM/arbiter side.
interface ecc_scrub8_if #(
    parameter int AW = 8
) ();
    logic          ram_busy;
    logic          ram_re;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [11:0]   ram_wdat;
    logic [11:0]   ram_rdat;

    modport master (
        input  ram_busy,
        input  ram_rdat,
        output ram_re,
        output ram_we,
        output ram_addr,
        output ram_wdat
    );

    modport slave (
        output ram_busy,
        output ram_rdat,
        input  ram_re,
        input  ram_we,
        input  ram_addr,
        input  ram_wdat
    );
endinterface

// File: rtl/ecc_scrub8.sv
// ecc_scrub8
// Background scrubber for an 8-bit-data / 12-bit Hamming RAM. Walks addresses
// 0..LAST_ADDR, feeds each word to an external SEC decoder and writes the
// re-encoded byte back whenever the decoder raises its alarm.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   scrub_en            : scrubbing runs while high
//   fwr_en, fwr_addr    : functional write snoop (cancels a pending writeback)
//   ram                 : RAM bus (ecc_scrub8_if.master)
//   dec_idat            : captured word to decoder
//   dec_odat, dec_alarm : corrected byte and nonzero-syndrome flag
//   err_clr             : synchronous clear of err_cnt
//   err_cnt             : saturating count of alarmed words
//   last_err_addr       : address of the most recent alarmed word
//   pass_done           : one-cycle pulse after LAST_ADDR completes
module ecc_scrub8 #(
    parameter int AW        = 8,
    parameter int LAST_ADDR = 255,
    parameter int GAP_CYC   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scrub_en,
    input  logic              fwr_en,
    input  logic [AW-1:0]     fwr_addr,
    ecc_scrub8_if.master      ram,
    output logic [11:0]       dec_idat,
    input  logic [7:0]        dec_odat,
    input  logic              dec_alarm,
    input  logic              err_clr,
    output logic [15:0]       err_cnt,
    output logic [AW-1:0]     last_err_addr,
    output logic              pass_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_CHK  = 3'd3,
        S_WB   = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_A   = AW'(LAST_ADDR);
    localparam logic [15:0]   GAP_LAST = 16'(GAP_CYC - 1);

    // Hamming(12,8) encoder: parity at positions 1,2,4,8 (bits 0,1,3,7).
    function automatic logic [11:0] encode(input logic [7:0] b);
        logic p1;
        logic p2;
        logic p4;
        logic p8;
        p1 = b[0] ^ b[1] ^ b[3] ^ b[4] ^ b[6];
        p2 = b[0] ^ b[2] ^ b[3] ^ b[5] ^ b[6];
        p4 = b[1] ^ b[2] ^ b[3] ^ b[7];
        p8 = b[4] ^ b[5] ^ b[6] ^ b[7];
        return {b[7:4], p8, b[3:1], p4, b[0], p2, p1};
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   addr_r;
    logic [11:0]     word_r;
    logic [11:0]     wbuf_r;
    logic            abort_r;
    logic [15:0]     gap_r;

    logic            snoop_hit_s;
    logic            wb_skip_s;
    logic            advance_s;
    logic            alarm_hit_s;
    state_t          after_s;

    // Snoop, writeback-skip and word-completion qualifiers.
    always_comb begin
        snoop_hit_s = 1'b0;
        wb_skip_s   = 1'b0;
        advance_s   = 1'b0;
        alarm_hit_s = 1'b0;
        if ((state_r == S_CAP) || (state_r == S_CHK) || (state_r == S_WB)) begin
            snoop_hit_s = fwr_en && (fwr_addr == addr_r);
        end else begin
            snoop_hit_s = 1'b0;
        end
        // A functional write to this address makes our corrected copy stale,
        // including one landing in the very cycle we would write.
        wb_skip_s = (state_r == S_WB) && (abort_r || snoop_hit_s);
        if (state_r == S_CHK) begin
            alarm_hit_s = dec_alarm;
            advance_s   = !dec_alarm;
        end else if (state_r == S_WB) begin
            alarm_hit_s = 1'b0;
            advance_s   = wb_skip_s || !ram.ram_busy;
        end else begin
            alarm_hit_s = 1'b0;
            advance_s   = 1'b0;
        end
    end

    // Where the FSM goes once a word is finished.
    always_comb begin
        after_s = S_IDLE;
        if (GAP_CYC > 0) begin
            after_s = S_GAP;
        end else if (scrub_en) begin
            after_s = S_RD;
        end else begin
            after_s = S_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  state_nxt_s = scrub_en ? S_RD : S_IDLE;
            S_RD:    state_nxt_s = ram.ram_busy ? S_RD : S_CAP;
            S_CAP:   state_nxt_s = S_CHK;
            S_CHK:   state_nxt_s = dec_alarm ? S_WB : after_s;
            S_WB:    state_nxt_s = advance_s ? after_s : S_WB;
            S_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_nxt_s = scrub_en ? S_RD : S_IDLE;
                end else begin
                    state_nxt_s = S_GAP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM outputs: RAM strobes, always withheld while the functional port owns the RAM.
    always_comb begin
        ram.ram_re = 1'b0;
        ram.ram_we = 1'b0;
        if (state_r == S_RD) begin
            ram.ram_re = !ram.ram_busy;
        end else if (state_r == S_WB) begin
            ram.ram_we = !ram.ram_busy && !wb_skip_s;
        end else begin
            ram.ram_re = 1'b0;
            ram.ram_we = 1'b0;
        end
    end

    // Address pointer, captured word, writeback buffer, abort flag, gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= '0;
            word_r    <= 12'h000;
            wbuf_r    <= 12'h000;
            abort_r   <= 1'b0;
            gap_r     <= 16'h0000;
            pass_done <= 1'b0;
        end else begin
            pass_done <= advance_s && (addr_r == LAST_A);
            if (advance_s) begin
                addr_r <= (addr_r == LAST_A) ? '0 : addr_r + 1'b1;
            end
            if (state_r == S_CAP) begin
                word_r <= ram.ram_rdat;
            end
            if (alarm_hit_s) begin
                wbuf_r <= encode(dec_odat);
            end
            if (state_r == S_RD) begin
                abort_r <= 1'b0;
            end else if (snoop_hit_s) begin
                abort_r <= 1'b1;
            end
            if (advance_s) begin
                gap_r <= 16'h0000;
            end else if (state_r == S_GAP) begin
                gap_r <= gap_r + 16'h0001;
            end
        end
    end

    // Error statistics; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt       <= 16'h0000;
            last_err_addr <= '0;
        end else begin
            if (err_clr) begin
                err_cnt <= 16'h0000;
            end else if (alarm_hit_s && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'h0001;
            end
            if (alarm_hit_s) begin
                last_err_addr <= addr_r;
            end
        end
    end

    assign ram.ram_addr = addr_r;
    assign ram.ram_wdat = wbuf_r;
    assign dec_idat     = word_r;

endmodule

// File: tb/tb_ecc_scrub8.sv
// tb_ecc_scrub8
// Self-checking bench for ecc_scrub8: behavioural RAM, behavioural SEC decoder,
// and a position-based Hamming reference used to predict writebacks.
module tb_ecc_scrub8;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scrub_en = 1'b0;
    logic        fwr_en = 1'b0;
    logic [7:0]  fwr_addr = 8'h00;
    logic        err_clr = 1'b0;
    logic        busy = 1'b0;
    logic [11:0] dec_idat;
    logic [7:0]  dec_odat;
    logic        dec_alarm;
    logic [15:0] err_cnt;
    logic [7:0]  last_err_addr;
    logic        pass_done;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int viol = 0;

    logic [11:0] mem [256];
    logic [7:0]  dat [256];
    logic [11:0] rdat_r = 12'h000;

    int          rd_cyc[$];
    logic [7:0]  rd_adr[$];
    int          wr_cyc[$];
    logic [7:0]  wr_adr[$];
    logic [11:0] wr_dat[$];
    int          pd_cyc[$];
    logic [7:0]  pd_adr[$];
    logic [7:0]  exp_adr[$];
    logic [11:0] exp_dat[$];

    ecc_scrub8_if #(.AW(AW)) bus ();

    ecc_scrub8 #(.AW(AW), .LAST_ADDR(255), .GAP_CYC(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scrub_en      (scrub_en),
        .fwr_en        (fwr_en),
        .fwr_addr      (fwr_addr),
        .ram           (bus),
        .dec_idat      (dec_idat),
        .dec_odat      (dec_odat),
        .dec_alarm     (dec_alarm),
        .err_clr       (err_clr),
        .err_cnt       (err_cnt),
        .last_err_addr (last_err_addr),
        .pass_done     (pass_done)
    );

    // Hamming encode: place data at non-power-of-two positions, then set the
    // parity bits to the syndrome of the data-only word.
    function automatic logic [11:0] ref_encode(input logic [7:0] b);
        logic [11:0] w;
        int s;
        w = 12'h000;
        w[2] = b[0]; w[4] = b[1]; w[5] = b[2]; w[6] = b[3];
        w[8] = b[4]; w[9] = b[5]; w[10] = b[6]; w[11] = b[7];
        s = 0;
        for (int i = 0; i < 12; i++) if (w[i]) s = s ^ (i + 1);
        w[0] = s[0]; w[1] = s[1]; w[3] = s[2]; w[7] = s[3];
        return w;
    endfunction

    // SEC decode: syndrome = XOR of 1-based positions of set bits; {alarm, byte}.
    function automatic logic [8:0] ref_decode(input logic [11:0] w);
        logic [11:0] c;
        int s;
        c = w;
        s = 0;
        for (int i = 0; i < 12; i++) if (w[i]) s = s ^ (i + 1);
        if (s != 0 && s <= 12) c[s-1] = ~c[s-1];
        return {(s != 0), c[11:8], c[6:4], c[2]};
    endfunction

    assign {dec_alarm, dec_odat} = ref_decode(dec_idat);
    assign bus.ram_busy = busy;
    assign bus.ram_rdat = rdat_r;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.ram_re) rdat_r <= mem[bus.ram_addr];
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdat;
    end

    always @(negedge clk) begin
        if (bus.ram_re) begin rd_cyc.push_back(cyc); rd_adr.push_back(bus.ram_addr); end
        if (bus.ram_we) begin
            wr_cyc.push_back(cyc); wr_adr.push_back(bus.ram_addr); wr_dat.push_back(bus.ram_wdat);
        end
        if (pass_done) begin pd_cyc.push_back(cyc); pd_adr.push_back(bus.ram_addr); end
        if ((bus.ram_re && bus.ram_we) || (busy && (bus.ram_re || bus.ram_we))) viol <= viol + 1;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic goto(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; scrub_en = 1'b0; busy = 1'b0; fwr_en = 1'b0; err_clr = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        pd_cyc.delete(); pd_adr.delete();
    endtask

    task automatic fill_clean();
        for (int i = 0; i < 256; i++) begin
            dat[i] = 8'($urandom_range(0, 255));
            mem[i] <= ref_encode(dat[i]);
        end
        step(1);
    endtask

    task automatic corrupt(input logic [7:0] a, input logic [7:0] b, input int bitn);
        logic [11:0] m;
        m = 12'h001 << bitn;
        dat[a] = b;
        mem[a] <= ref_encode(b) ^ m;
        step(1);
    endtask

    // Expected writebacks for one full pass over the current memory image.
    task automatic build_model();
        logic [8:0] d;
        exp_adr.delete(); exp_dat.delete();
        for (int i = 0; i < 256; i++) begin
            d = ref_decode(mem[i]);
            if (d[8]) begin exp_adr.push_back(8'(i)); exp_dat.push_back(ref_encode(d[7:0])); end
        end
    endtask

    task automatic wait_read(input logic [7:0] a, output int c, output bit ok);
        ok = 1'b0; c = 0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            step(1);
            foreach (rd_adr[i]) if (!ok && rd_adr[i] == a) begin ok = 1'b1; c = rd_cyc[i]; end
        end
    endtask

    task automatic wait_pass(input bit rnd_busy, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4000 && !ok; n++) begin
            if (rnd_busy) busy = ($urandom_range(0, 3) == 0);
            step(1);
            ok = (pd_cyc.size() > 0);
        end
        busy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_chk++;
        if ({bus.ram_re, bus.ram_we, pass_done, bus.ram_addr, bus.ram_wdat, dec_idat, err_cnt, last_err_addr} !== '0)
            $display("FAIL reset_outputs: got re=%b we=%b pd=%b addr=%h wdat=%h idat=%h cnt=%h last=%h want all 0",
                     bus.ram_re, bus.ram_we, pass_done, bus.ram_addr, bus.ram_wdat, dec_idat, err_cnt, last_err_addr);
        else n_pass++;
        do_reset();
        step(3);
        n_chk++;
        if ({bus.ram_re, bus.ram_we, bus.ram_addr} !== '0)
            $display("FAIL idle_no_strobe: got re=%b we=%b addr=%h want 0", bus.ram_re, bus.ram_we, bus.ram_addr);
        else n_pass++;
    endtask

    task automatic test_clean_pass();
        bit ok;
        int bad;
        int nrd;
        int v0;
        do_reset(); fill_clean(); build_model();
        v0 = viol;
        scrub_en = 1'b1;
        wait_pass(1'b0, ok);
        scrub_en = 1'b0;
        step(6);
        n_chk++;
        if (!ok || pd_cyc.size() != 1) $display("FAIL clean_pass_done: got %0d pulses want 1", pd_cyc.size());
        else n_pass++;
        nrd = 0; bad = 0;
        foreach (rd_cyc[i]) if (ok && rd_cyc[i] < pd_cyc[0]) nrd++;
        for (int i = 0; i < 256; i++) begin
            if (rd_adr[i] != 8'(i)) bad++;
            if (i > 0 && rd_cyc[i] - rd_cyc[i-1] != 3) bad++;
        end
        n_chk++;
        if (nrd != 256) $display("FAIL clean_read_count: got %0d want 256", nrd); else n_pass++;
        n_chk++;
        if (bad != 0) $display("FAIL clean_read_order: got %0d bad spacings/addresses want 0", bad); else n_pass++;
        n_chk++;
        if (pd_cyc[0] - rd_cyc[0] != 768) $display("FAIL clean_pass_latency: got %0d want 768", pd_cyc[0] - rd_cyc[0]);
        else n_pass++;
        n_chk++;
        if (pd_adr[0] !== 8'h00) $display("FAIL clean_wrap: got %h want 00", pd_adr[0]); else n_pass++;
        n_chk++;
        if (wr_adr.size() != exp_adr.size()) $display("FAIL clean_no_write: got %0d writes want %0d", wr_adr.size(), exp_adr.size());
        else n_pass++;
        n_chk++;
        if (err_cnt !== 16'h0000) $display("FAIL clean_err_cnt: got %h want 0000", err_cnt); else n_pass++;
        n_chk++;
        if (viol != v0) $display("FAIL clean_strobe_rules: got %0d violations want 0", viol - v0); else n_pass++;
    endtask

    task automatic test_errors();
        bit ok;
        int bad;
        int v0;
        logic [8:0] d;
        do_reset(); fill_clean();
        corrupt(8'h10, 8'hA5, 4);
        corrupt(8'h20, 8'h3C, 7);
        for (int k = 0; k < 3; k++) corrupt(8'(64 + 48 * k + $urandom_range(0, 47)), 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        build_model();
        v0 = viol;
        scrub_en = 1'b1;
        wait_pass(1'b0, ok);
        scrub_en = 1'b0;
        step(6);
        n_chk++;
        if (!ok) $display("FAIL err_pass_done: got none want 1"); else n_pass++;
        n_chk++;
        if (wr_adr.size() != exp_adr.size()) $display("FAIL err_write_count: got %0d want %0d", wr_adr.size(), exp_adr.size());
        else n_pass++;
        foreach (exp_adr[i]) begin
            n_chk++;
            if (wr_adr[i] !== exp_adr[i] || wr_dat[i] !== exp_dat[i])
                $display("FAIL err_writeback[%0d]: got %h@%h want %h@%h", i, wr_dat[i], wr_adr[i], exp_dat[i], exp_adr[i]);
            else n_pass++;
        end
        n_chk++;
        if (wr_dat[0] !== ref_encode(8'hA5)) $display("FAIL err_a5_word: got %h want %h", wr_dat[0], ref_encode(8'hA5));
        else n_pass++;
        n_chk++;
        if (err_cnt !== 16'(exp_adr.size())) $display("FAIL err_cnt: got %h want %h", err_cnt, 16'(exp_adr.size()));
        else n_pass++;
        n_chk++;
        if (last_err_addr !== exp_adr[exp_adr.size()-1])
            $display("FAIL err_last_addr: got %h want %h", last_err_addr, exp_adr[exp_adr.size()-1]);
        else n_pass++;
        n_chk++;
        if (pd_cyc[0] - rd_cyc[0] != 768 + exp_adr.size())
            $display("FAIL err_pass_latency: got %0d want %0d", pd_cyc[0] - rd_cyc[0], 768 + exp_adr.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 256; i++) begin d = ref_decode(mem[i]); if (d[8]) bad++; end
        n_chk++;
        if (bad != 0) $display("FAIL err_mem_scrubbed: got %0d dirty words want 0", bad); else n_pass++;
        n_chk++;
        if (viol != v0) $display("FAIL err_strobe_rules: got %0d violations want 0", viol - v0); else n_pass++;
    endtask

    task automatic test_busy();
        bit ok;
        int rel;
        int wrel;
        int bad;
        int v0;
        do_reset(); fill_clean();
        corrupt(8'h00, 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        corrupt(8'h30, 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        build_model();
        v0 = viol;
        busy = 1'b1; scrub_en = 1'b1;
        step(6);
        busy = 1'b0; rel = cyc;
        step(3);
        busy = 1'b1;
        step(5);
        busy = 1'b0; wrel = cyc;
        wait_pass(1'b1, ok);
        scrub_en = 1'b0;
        step(6);
        n_chk++;
        if (rd_cyc[0] != rel) $display("FAIL busy_rd_release: got cycle %0d want %0d", rd_cyc[0], rel); else n_pass++;
        n_chk++;
        if (wr_cyc[0] != wrel || wr_adr[0] !== 8'h00)
            $display("FAIL busy_wb_release: got cycle %0d addr %h want cycle %0d addr 00", wr_cyc[0], wr_adr[0], wrel);
        else n_pass++;
        bad = (wr_adr.size() != exp_adr.size()) ? 1 : 0;
        foreach (exp_adr[i]) if (wr_adr[i] !== exp_adr[i] || wr_dat[i] !== exp_dat[i]) bad++;
        n_chk++;
        if (!ok || bad != 0) $display("FAIL busy_writebacks: got %0d differences (pass=%0d) want 0", bad, ok); else n_pass++;
        n_chk++;
        if (err_cnt !== 16'h0002) $display("FAIL busy_err_cnt: got %h want 0002", err_cnt); else n_pass++;
        n_chk++;
        if (viol != v0) $display("FAIL busy_strobe_rules: got %0d violations want 0", viol - v0); else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        bit ok_all;
        int c;
        logic [11:0] w5;
        logic [11:0] w9;
        do_reset(); fill_clean();
        corrupt(8'd5, 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        corrupt(8'd9, 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        corrupt(8'd12, 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        w5 = mem[5]; w9 = mem[9];
        scrub_en = 1'b1;
        ok_all = 1'b1;
        wait_read(8'd5, c, ok); ok_all &= ok;
        goto(c + 2); fwr_en = 1'b1; fwr_addr = 8'd5; step(1); fwr_en = 1'b0;
        wait_read(8'd9, c, ok); ok_all &= ok;
        goto(c + 3); fwr_en = 1'b1; fwr_addr = 8'd9; step(1); fwr_en = 1'b0;
        wait_read(8'd12, c, ok); ok_all &= ok;
        goto(c + 2); fwr_en = 1'b1; fwr_addr = 8'd13; step(1); fwr_en = 1'b0;
        step(10);
        scrub_en = 1'b0;
        step(6);
        n_chk++;
        if (!ok_all) $display("FAIL abort_reads_seen: got timeout want reads of 5/9/12"); else n_pass++;
        n_chk++;
        if (wr_adr.size() != 1 || wr_adr[0] !== 8'd12)
            $display("FAIL abort_writes: got %0d writes first at %h want 1 write at 0c", wr_adr.size(), wr_adr[0]);
        else n_pass++;
        n_chk++;
        if (mem[5] !== w5 || mem[9] !== w9)
            $display("FAIL abort_mem_untouched: got %h/%h want %h/%h", mem[5], mem[9], w5, w9);
        else n_pass++;
        n_chk++;
        if (err_cnt !== 16'h0003 || last_err_addr !== 8'd12)
            $display("FAIL abort_err_stats: got cnt %h last %h want 0003 0c", err_cnt, last_err_addr);
        else n_pass++;
    endtask

    task automatic test_saturate();
        bit ok;
        int c;
        do_reset(); fill_clean();
        corrupt(8'd2, 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        corrupt(8'd4, 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        force dut.err_cnt = 16'hFFFF;
        step(1);
        release dut.err_cnt;
        step(1);
        n_chk++;
        if (err_cnt !== 16'hFFFF) $display("FAIL sat_preload: got %h want ffff", err_cnt); else n_pass++;
        scrub_en = 1'b1;
        wait_read(8'd2, c, ok);
        goto(c + 3);
        n_chk++;
        if (!ok || err_cnt !== 16'hFFFF || last_err_addr !== 8'd2)
            $display("FAIL sat_hold: got cnt %h last %h want ffff 02", err_cnt, last_err_addr);
        else n_pass++;
        wait_read(8'd4, c, ok);
        goto(c + 2); err_clr = 1'b1; step(1); err_clr = 1'b0;
        n_chk++;
        if (!ok || err_cnt !== 16'h0000 || last_err_addr !== 8'd4)
            $display("FAIL sat_clear_wins: got cnt %h last %h want 0000 04", err_cnt, last_err_addr);
        else n_pass++;
        scrub_en = 1'b0;
        step(6);
    endtask

    task automatic test_reset_mid_wb();
        bit ok;
        int c;
        logic [11:0] w1;
        do_reset(); fill_clean();
        corrupt(8'd1, 8'($urandom_range(0, 255)), $urandom_range(0, 11));
        w1 = mem[1];
        scrub_en = 1'b1;
        wait_read(8'd1, c, ok);
        goto(c + 3); busy = 1'b1;
        step(2);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (!ok || {bus.ram_re, bus.ram_we, pass_done, bus.ram_addr, bus.ram_wdat, dec_idat, err_cnt, last_err_addr} !== '0)
            $display("FAIL rst_mid_wb_outputs: got we=%b addr=%h wdat=%h cnt=%h last=%h want all 0",
                     bus.ram_we, bus.ram_addr, bus.ram_wdat, err_cnt, last_err_addr);
        else n_pass++;
        scrub_en = 1'b0;
        step(2);
        busy = 1'b0;
        rst_n = 1'b1;
        step(4);
        n_chk++;
        if (wr_adr.size() != 0 || mem[1] !== w1)
            $display("FAIL rst_mid_wb_nowrite: got %0d writes mem %h want 0 writes mem %h", wr_adr.size(), mem[1], w1);
        else n_pass++;
        n_chk++;
        if ({bus.ram_re, bus.ram_we, bus.ram_addr, bus.ram_wdat, err_cnt, last_err_addr} !== '0)
            $display("FAIL rst_mid_wb_after: got addr=%h wdat=%h cnt=%h want 0", bus.ram_addr, bus.ram_wdat, err_cnt);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_pass();
        test_errors();
        test_busy();
        test_abort();
        test_saturate();
        test_reset_mid_wb();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
